// File: rtl/simmem_wresp_scheduler.sv
// Write-response scheduler for the simulated memory: tracks outstanding write bursts,
// ages each one by its simulated latency and releases responses in per-ID order.
module simmem_wresp_scheduler #(
  parameter int NumSlots   = 8,
  parameter int IDWidth    = 4,
  parameter int DelayWidth = 6
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [IDWidth-1:0]              req_id_i,
  input  logic [DelayWidth-1:0]           req_delay_i,
  output logic                            rel_valid_o,
  input  logic                            rel_ready_i,
  output logic [IDWidth-1:0]              rel_id_o,
  output logic [$clog2(NumSlots+1)-1:0]   occupancy_o
);

  localparam int OccWidth  = $clog2(NumSlots + 1);
  localparam int IdxWidth  = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int RankWidth = IdxWidth;

  // ST_IDLE: offer the oldest eligible slot | ST_HOLD: keep offering the latched slot until accepted
  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [IdxWidth-1:0]     r_lock_idx;
  logic [NumSlots-1:0]     r_valid;
  logic [IDWidth-1:0]      r_id   [NumSlots];
  logic [DelayWidth-1:0]   r_cnt  [NumSlots];
  logic [RankWidth-1:0]    r_rank [NumSlots];
  logic [OccWidth-1:0]     r_occ;

  logic [NumSlots-1:0]     w_elig;
  logic                    w_any_elig;
  logic [IdxWidth-1:0]     w_sel_idx;
  logic [RankWidth-1:0]    w_best_rank;
  logic [IdxWidth-1:0]     w_free_idx;
  logic [IdxWidth-1:0]     w_rel_idx;
  logic                    w_rel_fire;
  logic                    w_ins;
  logic [RankWidth-1:0]    w_ins_rank;

  // A slot is blocked while an older burst with the same ID is still pending.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NumSlots; i++) begin
      w_elig[i] = r_valid[i] && (r_cnt[i] == '0);
      for (int j = 0; j < NumSlots; j++) begin
        if (r_valid[j] && (r_id[j] == r_id[i]) && (r_rank[j] < r_rank[i])) begin
          w_elig[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_any_elig  = 1'b0;
    w_sel_idx   = '0;
    w_best_rank = '1;
    for (int i = 0; i < NumSlots; i++) begin
      if (w_elig[i] && (!w_any_elig || (r_rank[i] < w_best_rank))) begin
        w_any_elig  = 1'b1;
        w_sel_idx   = IdxWidth'(i);
        w_best_rank = r_rank[i];
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rel_valid_o = 1'b0;
    w_rel_idx   = w_sel_idx;
    case (r_state)
      ST_IDLE: begin
        rel_valid_o = w_any_elig;
        if (w_any_elig && !rel_ready_i) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        rel_valid_o = 1'b1;
        w_rel_idx   = r_lock_idx;
        if (rel_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_rel_fire  = rel_valid_o && rel_ready_i;
  assign req_ready_o = (r_occ != OccWidth'(NumSlots));
  assign w_ins       = req_valid_i && req_ready_o;
  assign w_ins_rank  = RankWidth'(r_occ - OccWidth'(w_rel_fire));
  assign rel_id_o    = rel_valid_o ? r_id[w_rel_idx] : '0;
  assign occupancy_o = r_occ;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_lock_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_HOLD)) begin
        r_lock_idx <= w_sel_idx;
      end
    end
  end

  // Insert and release may hit different slots on the same edge; the new slot is never the released one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        r_id[i]   <= '0;
        r_cnt[i]  <= '0;
        r_rank[i] <= '0;
      end
    end else begin
      r_occ <= r_occ + OccWidth'(w_ins) - OccWidth'(w_rel_fire);
      for (int i = 0; i < NumSlots; i++) begin
        if (r_valid[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - DelayWidth'(1);
        end
        if (w_rel_fire && r_valid[i] && (r_rank[i] > r_rank[w_rel_idx])) begin
          r_rank[i] <= r_rank[i] - RankWidth'(1);
        end
        if (w_rel_fire && (IdxWidth'(i) == w_rel_idx)) begin
          r_valid[i] <= 1'b0;
        end
        if (w_ins && (IdxWidth'(i) == w_free_idx)) begin
          r_valid[i] <= 1'b1;
          r_id[i]    <= req_id_i;
          r_cnt[i]   <= req_delay_i;
          r_rank[i]  <= w_ins_rank;
        end
      end
    end
  end

endmodule
